// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-look-ahead adder with valid/ready handshake.
// WIDTH is split into GROUP-bit look-ahead groups, and each group is one
// pipeline stage, so results appear NGRP cycles after the operands are accepted.
// Optional macro CLA_SUB_EN adds a 'sub' input that selects A-B (A + ~B + 1).
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NGRP = WIDTH / GROUP;

  if ((GROUP < 1) || (GROUP > 8) || ((WIDTH % GROUP) != 0)) begin : g_param_check
    $error("cla_pipe_adder: WIDTH must be a multiple of GROUP, GROUP in 1..8");
  end

  // One look-ahead group. Every carry is the flattened sum-of-products
  // c[i+1] = g[i] | p[i]&g[i-1] | ... | p[i]..p[0]&ci, so nothing ripples.
  // Returns {carry into group MSB, group carry-out, group sum}.
  function automatic logic [GROUP+1:0] cla_group(input logic [GROUP-1:0] x,
                                                 input logic [GROUP-1:0] y,
                                                 input logic             ci);
    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP:0]   c;
    logic             t;
    p    = x ^ y;
    g    = x & y;
    c    = '0;
    c[0] = ci;
    for (int unsigned i = 0; i < GROUP; i++) begin
      t = ci;
      for (int unsigned j = 0; j <= i; j++) t = t & p[j];
      c[i+1] = t;
      for (int unsigned j = 0; j <= i; j++) begin
        t = g[j];
        for (int unsigned m = j + 1; m <= i; m++) t = t & p[m];
        c[i+1] = c[i+1] | t;
      end
    end
    // c[GROUP] is the group carry-out, G | P&ci, with G/P the group terms.
    return {c[GROUP-1], c[GROUP], p ^ c[GROUP-1:0]};
  endfunction

  // Stage registers: stage k holds finished sum bits for groups 0..k plus the
  // operand bits still to be added, the carry into group k+1 and a valid bit.
  logic [WIDTH-1:0] st_s [NGRP];
  logic [WIDTH-1:0] st_a [NGRP];
  logic [WIDTH-1:0] st_b [NGRP];
  logic             st_c [NGRP];
  logic             st_o [NGRP];
  logic             st_v [NGRP];

  logic [WIDTH-1:0] src_s [NGRP];
  logic [WIDTH-1:0] src_a [NGRP];
  logic [WIDTH-1:0] src_b [NGRP];
  logic             src_c [NGRP];
  logic             src_v [NGRP];
  logic [WIDTH-1:0] nx_s  [NGRP];
  logic [GROUP+1:0] grp_r [NGRP];

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c_first;

  // Subtraction is folded into the operands at acceptance, so the mode
  // travels down the pipe with the data.
  always_comb begin
    b_eff   = b;
    c_first = cin;
`ifdef CLA_SUB_EN
    if (sub) begin
      b_eff   = ~b;
      c_first = 1'b1;
    end
`endif
  end

  // Global stall: the whole pipe moves only when the output slot is free.
  always_comb begin
    advance  = !st_v[NGRP-1] || out_ready;
    in_ready = advance;
  end

  // Per-stage source selection and group addition.
  always_comb begin
    src_s[0] = '0;
    src_a[0] = a;
    src_b[0] = b_eff;
    src_c[0] = c_first;
    src_v[0] = in_valid;
    for (int unsigned k = 1; k < NGRP; k++) begin
      src_s[k] = st_s[k-1];
      src_a[k] = st_a[k-1];
      src_b[k] = st_b[k-1];
      src_c[k] = st_c[k-1];
      src_v[k] = st_v[k-1];
    end
    for (int unsigned k = 0; k < NGRP; k++) begin
      grp_r[k] = cla_group(src_a[k][k*GROUP +: GROUP], src_b[k][k*GROUP +: GROUP], src_c[k]);
      nx_s[k]  = src_s[k];
      nx_s[k][k*GROUP +: GROUP] = grp_r[k][GROUP-1:0];
    end
  end

  // Pipeline registers: cleared asynchronously, held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NGRP; k++) begin
        st_s[k] <= '0;
        st_a[k] <= '0;
        st_b[k] <= '0;
        st_c[k] <= 1'b0;
        st_o[k] <= 1'b0;
        st_v[k] <= 1'b0;
      end
    end else if (advance) begin
      for (int unsigned k = 0; k < NGRP; k++) begin
        st_s[k] <= nx_s[k];
        st_a[k] <= src_a[k];
        st_b[k] <= src_b[k];
        st_c[k] <= grp_r[k][GROUP];
        st_o[k] <= grp_r[k][GROUP+1] ^ grp_r[k][GROUP];
        st_v[k] <= src_v[k];
      end
    end
  end

  // Outputs come straight from the last stage.
  always_comb begin
    out_valid = st_v[NGRP-1];
    sum       = st_s[NGRP-1];
    cout      = st_c[NGRP-1];
    ovf       = st_o[NGRP-1];
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed self-checking bench for cla_pipe_adder at WIDTH=16, GROUP=4.
// Define CLA_SUB_EN for both files to exercise the subtract mode.
module tb_cla_pipe_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
`ifdef CLA_SUB_EN
  logic        sub = 1'b0;
`endif
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int checks = 0;
  int failures = 0;
  logic [17:0] expq[$];

  logic [15:0] ta [8] = '{16'h1234, 16'hFFFF, 16'h8000, 16'h0F0F, 16'h7FFF, 16'hAAAA, 16'h0000, 16'hC3A5};
  logic [15:0] tb [8] = '{16'h4321, 16'h0001, 16'h8000, 16'hF0F0, 16'h7FFF, 16'h5555, 16'h0000, 16'h5A3C};
  logic        tc [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  cla_pipe_adder #(.WIDTH(16), .GROUP(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef CLA_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Plain-integer reference: {ovf, cout, sum}.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic ci);
    logic [16:0] full;
    logic        c15;
    full = {1'b0, x} + {1'b0, y} + {16'd0, ci};
    c15  = full[15] ^ x[15] ^ y[15];
    return {c15 ^ full[16], full[16], full[15:0]};
  endfunction

  task automatic drive(input logic v, input logic [15:0] x, input logic [15:0] y, input logic ci);
    in_valid = v;
    a = x;
    b = y;
    cin = ci;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, ovf, cout, sum} !== 19'h0)
      begin failures++; $display("FAIL reset_outputs got=%h exp=0", {out_valid, ovf, cout, sum}); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1)
      begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_single;
    @(negedge clk);
    drive(1'b1, 16'h0003, 16'h0001, 1'b0);
    #1;
    checks++;
    if (in_ready !== 1'b1)
      begin failures++; $display("FAIL single_accept got=%b exp=1", in_ready); end
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n == 1) drive(1'b0, '0, '0, 1'b0);
      checks++;
      if (out_valid !== (n == 4))
        begin failures++; $display("FAIL single_latency cyc=%0d got=%b exp=%b", n, out_valid, (n == 4)); end
    end
    checks++;
    if ({ovf, cout, sum} !== 18'h00004)
      begin failures++; $display("FAIL single_value got=%h exp=00004", {ovf, cout, sum}); end
  endtask

  task automatic test_carry;
    @(negedge clk); drive(1'b1, 16'hFFFF, 16'h0000, 1'b1);
    @(negedge clk); drive(1'b1, 16'h7FFF, 16'h0001, 1'b0);
    @(negedge clk); drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, ovf, cout, sum} !== {1'b1, 1'b0, 1'b1, 16'h0000})
      begin failures++; $display("FAIL carry_chain got=%h exp=%h", {out_valid, ovf, cout, sum}, {1'b1, 1'b0, 1'b1, 16'h0000}); end
    @(negedge clk);
    checks++;
    if ({out_valid, ovf, cout, sum} !== {1'b1, 1'b1, 1'b0, 16'h8000})
      begin failures++; $display("FAIL carry_overflow got=%h exp=%h", {out_valid, ovf, cout, sum}, {1'b1, 1'b1, 1'b0, 16'h8000}); end
  endtask

  task automatic test_back_to_back;
    int got = 0;
    logic [17:0] e;
    expq.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i < 8) drive(1'b1, ta[i], tb[i], tc[i]);
      else drive(1'b0, '0, '0, 1'b0);
      #1;
      checks++;
      if (in_ready !== 1'b1)
        begin failures++; $display("FAIL b2b_in_ready cyc=%0d got=%b exp=1", i, in_ready); end
      if (in_valid && in_ready) expq.push_back(model(a, b, cin));
      checks++;
      if (out_valid !== (i >= 4 && i < 12))
        begin failures++; $display("FAIL b2b_out_valid cyc=%0d got=%b exp=%b", i, out_valid, (i >= 4 && i < 12)); end
      if (out_valid && out_ready) begin
        got++;
        checks++;
        if (expq.size() == 0)
          begin failures++; $display("FAIL b2b_extra got=%h exp=none", {ovf, cout, sum}); end
        else begin
          e = expq.pop_front();
          if ({ovf, cout, sum} !== e)
            begin failures++; $display("FAIL b2b_data got=%h exp=%h", {ovf, cout, sum}, e); end
        end
      end
    end
    checks++;
    if (got != 8 || expq.size() != 0)
      begin failures++; $display("FAIL b2b_count got=%0d exp=8 left=%0d", got, expq.size()); end
  endtask

  task automatic test_backpressure;
    int sent = 0;
    int got = 0;
    logic held = 1'b0;
    logic stalled = 1'b0;
    logic [18:0] prev = '0;
    logic [17:0] e;
    expq.delete();
    for (int c = 0; c < 40 && got < 10; c++) begin
      @(negedge clk);
      if (sent < 10) drive(1'b1, ta[sent % 8] ^ 16'(sent), tb[sent % 8], tc[sent % 8]);
      else drive(1'b0, '0, '0, 1'b0);
      out_ready = !(c >= 3 && c < 9);
      #1;
      checks++;
      if (in_ready !== (!out_valid || out_ready))
        begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=%b", c, in_ready, (!out_valid || out_ready)); end
      if (!in_ready) stalled = 1'b1;
      if (held) begin
        checks++;
        if ({out_valid, ovf, cout, sum} !== prev)
          begin failures++; $display("FAIL bp_frozen cyc=%0d got=%h exp=%h", c, {out_valid, ovf, cout, sum}, prev); end
      end
      held = out_valid && !out_ready;
      prev = {out_valid, ovf, cout, sum};
      if (in_valid && in_ready) begin
        expq.push_back(model(a, b, cin));
        sent++;
      end
      if (out_valid && out_ready) begin
        got++;
        checks++;
        if (expq.size() == 0)
          begin failures++; $display("FAIL bp_extra got=%h exp=none", {ovf, cout, sum}); end
        else begin
          e = expq.pop_front();
          if ({ovf, cout, sum} !== e)
            begin failures++; $display("FAIL bp_data got=%h exp=%h", {ovf, cout, sum}, e); end
        end
      end
    end
    out_ready = 1'b1;
    checks++;
    if (got != 10 || expq.size() != 0 || !stalled)
      begin failures++; $display("FAIL bp_count got=%0d exp=10 left=%0d stalled=%b", got, expq.size(), stalled); end
  endtask

  task automatic test_reset_midflight;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, ta[i], tb[i], tc[i]);
    end
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0);
    checks++;
    if (out_valid !== 1'b1)
      begin failures++; $display("FAIL mid_pre_valid got=%b exp=1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, ovf, cout, sum} !== 19'h0)
      begin failures++; $display("FAIL mid_async_clear got=%h exp=0", {out_valid, ovf, cout, sum}); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0)
        begin failures++; $display("FAIL mid_no_ghost cyc=%0d got=%b exp=0", i, out_valid); end
    end
    drive(1'b1, 16'h1234, 16'h4321, 1'b0);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n == 1) drive(1'b0, '0, '0, 1'b0);
    end
    checks++;
    if ({out_valid, ovf, cout, sum} !== {1'b1, 1'b0, 1'b0, 16'h5555})
      begin failures++; $display("FAIL mid_new_op got=%h exp=%h", {out_valid, ovf, cout, sum}, {1'b1, 1'b0, 1'b0, 16'h5555}); end
  endtask

`ifdef CLA_SUB_EN
  task automatic test_sub;
    @(negedge clk); sub = 1'b1; drive(1'b1, 16'h0005, 16'h0007, 1'b0);
    @(negedge clk); sub = 1'b1; drive(1'b1, 16'h8000, 16'h0001, 1'b0);
    @(negedge clk); sub = 1'b0; drive(1'b1, 16'h0005, 16'h0007, 1'b1);
    @(negedge clk); drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    checks++;
    if ({out_valid, ovf, cout, sum} !== {1'b1, 1'b0, 1'b0, 16'hFFFE})
      begin failures++; $display("FAIL sub_neg got=%h exp=%h", {out_valid, ovf, cout, sum}, {1'b1, 1'b0, 1'b0, 16'hFFFE}); end
    @(negedge clk);
    checks++;
    if ({out_valid, ovf, cout, sum} !== {1'b1, 1'b1, 1'b1, 16'h7FFF})
      begin failures++; $display("FAIL sub_ovf got=%h exp=%h", {out_valid, ovf, cout, sum}, {1'b1, 1'b1, 1'b1, 16'h7FFF}); end
    @(negedge clk);
    checks++;
    if ({out_valid, ovf, cout, sum} !== {1'b1, 1'b0, 1'b0, 16'h000D})
      begin failures++; $display("FAIL sub_mode_switch got=%h exp=%h", {out_valid, ovf, cout, sum}, {1'b1, 1'b0, 1'b0, 16'h000D}); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_carry();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
`ifdef CLA_SUB_EN
    test_sub();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
